// File: rtl/counter_4bit.sv
// counter_4bit
//   Loadable up/down binary counter with synchronous clear, a
//   combinational terminal-count flag and a registered wrap pulse.
//   The count range is 0..MAX_VAL and all arithmetic is modulo MAX_VAL+1.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset (out=0, wrap=0)
//   en       in   1      count enable
//   up_dn    in   1      1 = count up, 0 = count down
//   load     in   1      synchronous load strobe
//   load_val in   WIDTH  load value, saturated to MAX_VAL
//   clr      in   1      synchronous functional clear
//   out      out  WIDTH  registered count
//   tc       out  1      terminal count for the current direction
//   wrap     out  1      one-cycle pulse after the count wrapped
//
// Per-edge priority: rst > clr > load > en > hold.
module counter_4bit #(
  parameter int unsigned          WIDTH   = 4,
  parameter logic [WIDTH-1:0]     MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;

  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_sat;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;

  assign w_at_max   = (r_out == MAX_VAL);
  assign w_at_zero  = (r_out == '0);

  // Loads above the terminal value clamp so out never leaves 0..MAX_VAL.
  assign w_load_sat = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Wrap points are explicit rather than relying on 2^WIDTH overflow,
  // which keeps non-power-of-two MAX_VAL builds correct.
  assign w_inc      = w_at_max  ? '0      : r_out + WIDTH'(1);
  assign w_dec      = w_at_zero ? MAX_VAL : r_out - WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else if (clr) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_out  <= w_load_sat;
      r_wrap <= 1'b0;
    end else if (en) begin
      if (up_dn) begin
        r_out  <= w_inc;
        r_wrap <= w_at_max;
      end else begin
        r_out  <= w_dec;
        r_wrap <= w_at_zero;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign out  = r_out;
  assign wrap = r_wrap;
  // tc follows the live direction input, so it flips as soon as up_dn does.
  assign tc   = up_dn ? w_at_max : w_at_zero;

endmodule

// File: tb/tb_counter_4bit.sv
// Directed bench for counter_4bit: the default 4-bit build (dut A) and a
// MAX_VAL=9 build (dut B). The driver changes inputs on the falling edge
// and queues the hand-computed result expected after the next rising
// edge; a monitor samples 1ns after each rising edge and checks it.
module tb_counter_4bit;

  logic       clk;
  logic       a_rst, a_en, a_up, a_load, a_clr;
  logic [3:0] a_lv, a_out;
  logic       a_tc, a_wrap;
  logic       b_rst, b_en, b_up, b_load, b_clr;
  logic [3:0] b_lv, b_out;
  logic       b_tc, b_wrap;

  counter_4bit #(.WIDTH(4)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up_dn(a_up), .load(a_load),
    .load_val(a_lv), .clr(a_clr), .out(a_out), .tc(a_tc), .wrap(a_wrap)
  );

  counter_4bit #(.WIDTH(4), .MAX_VAL(4'd9)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up_dn(b_up), .load(b_load),
    .load_val(b_lv), .clr(b_clr), .out(b_out), .tc(b_tc), .wrap(b_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         sel;   // 0 = dut A, 1 = dut B
    logic [3:0] out;
    logic       wrap;
    logic       tc;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: every rising edge that has a queued expectation is checked.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      logic [3:0] o;
      logic       w, t;
      e = q.pop_front();
      o = e.sel ? b_out  : a_out;
      w = e.sel ? b_wrap : a_wrap;
      t = e.sel ? b_tc   : a_tc;
      checks++;
      if (o !== e.out || w !== e.wrap || t !== e.tc) begin
        errors++;
        $display("FAIL %s: got out=%0d wrap=%0b tc=%0b, want out=%0d wrap=%0b tc=%0b",
                 e.name, o, w, t, e.out, e.wrap, e.tc);
      end
    end
  end

  // Drive one cycle of inputs; if chk is set, queue the result expected
  // after the coming rising edge.
  task automatic go(input bit sel, input logic r, c, l, e, u,
                    input logic [3:0] lv, input bit chk, input string nm,
                    input logic [3:0] eo, input logic ew, input logic et);
    exp_t x;
    if (!sel) begin
      a_rst = r; a_clr = c; a_load = l; a_en = e; a_up = u; a_lv = lv;
    end else begin
      b_rst = r; b_clr = c; b_load = l; b_en = e; b_up = u; b_lv = lv;
    end
    if (chk) begin
      x.sel = sel; x.out = eo; x.wrap = ew; x.tc = et; x.name = nm;
      q.push_back(x);
    end
    @(negedge clk);
  endtask

  initial begin
    a_rst = 1; a_clr = 0; a_load = 0; a_en = 0; a_up = 1; a_lv = 0;
    b_rst = 1; b_clr = 0; b_load = 0; b_en = 0; b_up = 1; b_lv = 0;
    @(negedge clk);

    // 1: two reset edges, then five counting edges
    go(0, 1,0,0,0,1, 0, 0, "", 0,0,0);
    go(0, 1,0,0,0,1, 0, 1, "reset", 0,0,0);
    go(0, 0,0,0,1,1, 0, 1, "first_inc", 1,0,0);
    go(0, 0,0,0,1,1, 0, 0, "", 0,0,0);
    go(0, 0,0,0,1,1, 0, 0, "", 0,0,0);
    go(0, 0,0,0,1,1, 0, 0, "", 0,0,0);
    go(0, 0,0,0,1,1, 0, 1, "five_edges", 5,0,0);

    // 2: full up-count from 0, tc at 15, single-cycle wrap pulse
    go(0, 1,0,0,0,1, 0, 1, "reset2", 0,0,0);
    for (int i = 1; i <= 15; i++)
      go(0, 0,0,0,1,1, 0, 1, "up_count", 4'(i), 1'b0, (i == 15));
    go(0, 0,0,0,1,1, 0, 1, "up_wrap", 0,1,0);
    go(0, 0,0,0,0,1, 0, 1, "wrap_one_cycle", 0,0,0);

    // 3: count down from 0 wraps to 15, then 14,13,12
    go(0, 0,0,0,1,0, 0, 1, "down_wrap", 15,1,0);
    go(0, 0,0,0,1,0, 0, 1, "down_14", 14,0,0);
    go(0, 0,0,0,1,0, 0, 0, "", 0,0,0);
    go(0, 0,0,0,1,0, 0, 1, "down_12", 12,0,0);

    // 4: load beats enable, then hold with en=0
    go(0, 0,0,1,1,1, 9, 1, "load_9", 9,0,0);
    for (int i = 0; i < 4; i++)
      go(0, 0,0,0,0,1, 0, 1, "hold_9", 9,0,0);

    // 5: clr beats load; rst beats everything
    go(0, 0,0,1,0,1, 7, 1, "load_7", 7,0,0);
    go(0, 0,1,1,1,0, 3, 1, "clr_over_load", 0,0,1);  // down, at 0 -> tc
    go(0, 0,0,1,0,1, 6, 1, "load_6", 6,0,0);
    go(0, 1,0,0,1,1, 0, 1, "rst_mid_count", 0,0,0);
    go(0, 0,0,1,0,1, 5, 1, "load_5", 5,0,0);
    go(0, 1,0,1,1,1, 2, 1, "rst_over_load", 0,0,0);

    // 6: MAX_VAL=9 build
    go(1, 1,0,0,0,1, 0, 1, "b_reset", 0,0,0);
    for (int i = 1; i <= 9; i++)
      go(1, 0,0,0,1,1, 0, 1, "b_up_count", 4'(i), 1'b0, (i == 9));
    go(1, 0,0,0,1,1, 0, 1, "b_up_wrap", 0,1,0);
    go(1, 0,0,0,0,1, 0, 1, "b_wrap_clear", 0,0,0);
    go(1, 0,0,1,0,1, 12, 1, "b_load_sat", 9,0,1);
    go(1, 0,0,1,0,0, 0, 1, "b_load_0", 0,0,1);
    go(1, 0,0,0,1,0, 0, 1, "b_down_wrap", 9,1,0);
    go(1, 0,0,0,1,0, 0, 1, "b_down_8", 8,0,0);

    // Let the monitor drain; anything left over is a failure.
    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
